// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and configuration helpers for the pipelined CLA adder
package cla_pkg;

    localparam logic CLA_ADD = 1'b0;
    localparam logic CLA_SUB = 1'b1;

    function automatic int cla_nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit cla_cfg_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLOCK-bit generate/propagate lookahead adder
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products over g/p, not a ripple of the previous carry.
    always_comb begin
        logic t;
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & cin);
        end
    end

    assign sum      = p ^ c[BLOCK-1:0];
    assign cout     = c[BLOCK];
    assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - one-block-per-stage pipelined CLA adder/subtractor with valid/ready flow control
// Optional signed-overflow output enabled by CLA_PIPE_OVF_EN.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = cla_nblk(WIDTH, BLOCK);
    localparam int NOPS = (NBLK > 1) ? NBLK - 1 : 1;

    if (!cla_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
        $error("cla_adder_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             v_r   [NBLK];
    logic             c_r   [NBLK];
    logic [WIDTH-1:0] sum_r [NBLK];
    logic [WIDTH-1:0] a_r   [NOPS];
    logic [WIDTH-1:0] b_r   [NOPS];

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;
    assign b_eff    = (sub == CLA_SUB) ? ~b : b;
    assign cin_eff  = (sub == CLA_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] prev_sum;
        logic             stage_cin;
        logic             v_in;
        logic [BLOCK-1:0] blk_sum;
        logic             blk_cout;
        logic             blk_cmsb;

        if (k == 0) begin : g_first
            assign op_a      = a;
            assign op_b      = b_eff;
            assign prev_sum  = '0;
            assign stage_cin = cin_eff;
            assign v_in      = in_valid;
        end else begin : g_next
            assign op_a      = a_r[k-1];
            assign op_b      = b_r[k-1];
            assign prev_sum  = sum_r[k-1];
            assign stage_cin = c_r[k-1];
            assign v_in      = v_r[k-1];
        end

        cla_block #(.BLOCK(BLOCK)) u_blk (
            .a        (op_a[BLOCK-1:0]),
            .b        (op_b[BLOCK-1:0]),
            .cin      (stage_cin),
            .sum      (blk_sum),
            .cout     (blk_cout),
            .c_msb_in (blk_cmsb)
        );

        // Data registers only load on valid so the output holds across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r[k]   <= 1'b0;
                c_r[k]   <= 1'b0;
                sum_r[k] <= '0;
            end else if (advance) begin
                v_r[k] <= v_in;
                if (v_in) begin
                    c_r[k]                      <= blk_cout;
                    sum_r[k]                    <= prev_sum;
                    sum_r[k][k*BLOCK +: BLOCK] <= blk_sum;
                end
            end
        end

        if (k < NBLK - 1) begin : g_skew
            always_ff @(posedge clk) begin
                if (advance && v_in) begin
                    a_r[k] <= op_a >> BLOCK;
                    b_r[k] <= op_b >> BLOCK;
                end
            end
            logic unused_cmsb;
            assign unused_cmsb = blk_cmsb;
        end else begin : g_last
            logic unused_ops;
            assign unused_ops = ^{op_a, op_b};
`ifdef CLA_PIPE_OVF_EN
            logic cmsb_r;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cmsb_r <= 1'b0;
                end else if (advance && v_in) begin
                    cmsb_r <= blk_cmsb;
                end
            end
            assign ovf = cmsb_r ^ c_r[k];
`else
            logic unused_cmsb;
            assign unused_cmsb = blk_cmsb;
`endif
        end
    end

    assign out_valid = v_r[NBLK-1];
    assign sum       = sum_r[NBLK-1];
    assign cout      = c_r[NBLK-1];

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - directed self-checking bench for cla_adder_pipe (16-bit, 4-bit blocks)
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_PIPE_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tcin, input logic tsub, input logic [16:0] exp_r,
                           input logic exp_o);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " cout_sum"}, {15'd0, cout, sum}, {15'd0, exp_r});
`ifdef CLA_PIPE_OVF_EN
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_o});
`else
        if (exp_o === 1'bx) $display("note: %s has no overflow expectation", tag);
`endif
    endtask

    logic [15:0] bp_a   [5];
    logic [15:0] bp_b   [5];
    logic        bp_cin [5];
    logic        bp_sub [5];
    logic [16:0] bp_exp [5];

    initial begin
        int got;
        int sent;
        int seen;
        bit acc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset sum", {16'd0, sum}, 32'd0);
        check("reset cout", {31'd0, cout}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CLA_PIPE_OVF_EN
        check("reset ovf", {31'd0, ovf}, 32'd0);
`endif

        run_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b0);
        run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 1'b0);
        run_one("sub_nobor",  16'h0007, 16'h0005, 1'b1, 1'b1, 17'h1_0002, 1'b0);
        run_one("add_cin",    16'h1234, 16'h1111, 1'b1, 1'b0, 17'h0_2346, 1'b0);
        run_one("add_xblk",   16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h0_1000, 1'b0);
        run_one("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h0_8000, 1'b1);
        run_one("ovf_neg",    16'h8000, 16'h0001, 1'b0, 1'b1, 17'h1_7FFF, 1'b1);

        // Back-to-back: op i driven at step i-1 surfaces at step i+3.
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                check("thru sum", {16'd0, sum}, 32'(2 * (got + 1)));
                check("thru cycle", 32'(n), 32'(4 + got));
                got++;
            end
            in_valid = (n < 8);
            a = 16'(n + 1); b = 16'(n + 1); cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        end
        check("thru count", 32'(got), 32'd8);

        bp_a[0] = 16'h1111; bp_b[0] = 16'h2222; bp_cin[0] = 1'b0; bp_sub[0] = 1'b0; bp_exp[0] = 17'h0_3333;
        bp_a[1] = 16'h8000; bp_b[1] = 16'h8000; bp_cin[1] = 1'b0; bp_sub[1] = 1'b0; bp_exp[1] = 17'h1_0000;
        bp_a[2] = 16'h0100; bp_b[2] = 16'h0001; bp_cin[2] = 1'b0; bp_sub[2] = 1'b1; bp_exp[2] = 17'h1_00FF;
        bp_a[3] = 16'hABCD; bp_b[3] = 16'h1234; bp_cin[3] = 1'b1; bp_sub[3] = 1'b0; bp_exp[3] = 17'h0_BE02;
        bp_a[4] = 16'h0000; bp_b[4] = 16'h0001; bp_cin[4] = 1'b0; bp_sub[4] = 1'b1; bp_exp[4] = 17'h0_FFFF;

        // Ops offered on even steps, consumer stalls on steps 4..6.
        got = 0; sent = 0; acc = 1'b0;
        in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            out_ready = !(n >= 4 && n <= 6);
            if (!in_valid && sent < 5 && (n % 2) == 0) begin
                a = bp_a[sent]; b = bp_b[sent]; cin = bp_cin[sent]; sub = bp_sub[sent];
                in_valid = 1'b1;
            end
            #1;
            if (n >= 4 && n <= 6) begin
                check("stall in_ready", {31'd0, in_ready}, 32'd0);
                check("stall out_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (got < 5) check("bp result", {15'd0, cout, sum}, {15'd0, bp_exp[got]});
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        check("bp delivered", 32'(got), 32'd5);
        check("bp accepted", 32'(sent), 32'd5);

        // Reset with two ops in flight.
        @(negedge clk);
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        a = 16'h4444; b = 16'h1111; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h2222; b = 16'h1111;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid sum", {16'd0, sum}, 32'd0);
        check("rst_mid cout", {31'd0, cout}, 32'd0);
`ifdef CLA_PIPE_OVF_EN
        check("rst_mid ovf", {31'd0, ovf}, 32'd0);
`endif
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid no output", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
